// File: rtl/regfile_mp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_mp_pkg                                               |
// | Description : Shared defaults and clear-FSM state encodings for the        |
// |               multi-port PE register file.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package regfile_mp_pkg;

    // Switch phit width; register entries carry one phit each.
    localparam int PHIT_SIZE = 16;

    // Register-file defaults; $clog2(RF_DEPTH) equals the RF address width.
    localparam int RF_DEPTH  = 8;
    localparam int RF_NUM_RD = 2;
    localparam int RF_NUM_WR = 1;

    // Clear sweep FSM encodings.
    typedef logic [0:0] rf_state_t;
    localparam logic [0:0] RF_IDLE  = 1'b0;
    localparam logic [0:0] RF_CLEAR = 1'b1;

endpackage : regfile_mp_pkg
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_mp_if                                                |
// | Description : Bus bundle between a PE (master) and the register file       |
// |               (slave).                                                     |
// |   wen/wr_addr/d_in   : per-port write enable, address, data (flat slices)  |
// |   rd_addr            : per-port read address (flat slices)                 |
// |   d_out/rd_valid     : per-port read data and entry-valid bit              |
// |   clr_req            : one-cycle clear request                             |
// |   busy/wr_drop       : sweep-in-progress flag, dropped-write pulse         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface regfile_mp_if #(
    parameter int DWIDTH = regfile_mp_pkg::PHIT_SIZE,
    parameter int AWIDTH = $clog2(regfile_mp_pkg::RF_DEPTH),
    parameter int NUM_RD = regfile_mp_pkg::RF_NUM_RD,
    parameter int NUM_WR = regfile_mp_pkg::RF_NUM_WR
) ();

    logic [NUM_WR-1:0]        wen;
    logic [NUM_WR*AWIDTH-1:0] wr_addr;
    logic [NUM_WR*DWIDTH-1:0] d_in;
    logic [NUM_RD*AWIDTH-1:0] rd_addr;
    logic [NUM_RD*DWIDTH-1:0] d_out;
    logic [NUM_RD-1:0]        rd_valid;
    logic                     clr_req;
    logic                     busy;
    logic                     wr_drop;

    modport master (
        output wen, wr_addr, d_in, rd_addr, clr_req,
        input  d_out, rd_valid, busy, wr_drop
    );

    modport slave (
        input  wen, wr_addr, d_in, rd_addr, clr_req,
        output d_out, rd_valid, busy, wr_drop
    );

endinterface : regfile_mp_if
`default_nettype wire

// File: rtl/regfile_clr_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_clr_fsm                                              |
// | Description : Sequential clear-sweep engine. Walks every entry once after  |
// |               a clear request, and flags writes that arrive mid-sweep.     |
// |   clk, rst_n     : clock, asynchronous active-low reset                    |
// |   i_clr_req      : clear request pulse (ignored while sweeping)            |
// |   i_any_wen      : OR of all write enables                                 |
// |   o_busy         : high for exactly DEPTH cycles per sweep                 |
// |   o_wr_drop      : one-cycle pulse after a cycle with a write while busy   |
// |   o_clr_en       : storage should clear entry o_clr_addr this cycle        |
// |   o_clr_addr     : sweep pointer                                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module regfile_clr_fsm
    import regfile_mp_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               i_clr_req,
    input  wire               i_any_wen,
    output logic              o_busy,
    output logic              o_wr_drop,
    output logic              o_clr_en,
    output logic [AWIDTH-1:0] o_clr_addr
);

    localparam logic [AWIDTH-1:0] c_LAST_ADDR = AWIDTH'(DEPTH - 1);

    rf_state_t         r_state;
    logic [AWIDTH-1:0] r_ptr;
    logic              r_busy;
    logic              r_wr_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RF_IDLE;
            r_ptr     <= '0;
            r_busy    <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            // Reflects the busy level of the cycle the write was presented in.
            r_wr_drop <= i_any_wen & r_busy;
            case (r_state)
                RF_IDLE: begin
                    if (i_clr_req) begin
                        r_state <= RF_CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    // ptr wraps to 0 naturally at DEPTH since DEPTH is 2**AWIDTH.
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == c_LAST_ADDR) begin
                        r_state <= RF_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RF_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_wr_drop  = r_wr_drop;
    assign o_clr_en   = (r_state == RF_CLEAR);
    assign o_clr_addr = r_ptr;

endmodule : regfile_clr_fsm
`default_nettype wire

// File: rtl/regfile_mp.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_mp                                                   |
// | Description : Parametrised multi-port register file for CGRA PEs.          |
// |               NUM_WR fixed-priority write ports (highest index wins),      |
// |               NUM_RD read ports (combinational, or registered with         |
// |               write-through bypass), per-entry valid bits and a            |
// |               sequential clear sweep.                                      |
// |   clk, rst_n : clock, asynchronous active-low reset                        |
// |   bus        : regfile_mp_if slave modport (write/read/clear signals)      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DWIDTH   = PHIT_SIZE,
    parameter int DEPTH    = RF_DEPTH,
    parameter int AWIDTH   = $clog2(DEPTH),
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int NUM_WR   = RF_NUM_WR,
    parameter int READ_REG = 0
) (
    input  wire         clk,
    input  wire         rst_n,
    regfile_mp_if.slave bus
);

    logic [DWIDTH-1:0]        r_mem [DEPTH];
    logic [DEPTH-1:0]         r_valid;

    logic [AWIDTH-1:0]        w_wr_addr [NUM_WR];
    logic [DWIDTH-1:0]        w_wr_data [NUM_WR];
    logic [AWIDTH-1:0]        w_rd_addr [NUM_RD];

    logic [NUM_RD*DWIDTH-1:0] w_rd_data;
    logic [NUM_RD-1:0]        w_rd_vld;

    logic                     w_clr_en;
    logic [AWIDTH-1:0]        w_clr_addr;
    logic                     w_busy;
    logic                     w_wr_drop;

    // ------------------------------------------------------------------
    // Port slicing
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_port
            assign w_wr_addr[k] = bus.wr_addr[k*AWIDTH +: AWIDTH];
            assign w_wr_data[k] = bus.d_in[k*DWIDTH +: DWIDTH];
        end
        for (genvar j = 0; j < NUM_RD; j++) begin : g_rd_port
            assign w_rd_addr[j] = bus.rd_addr[j*AWIDTH +: AWIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Clear sweep engine
    // ------------------------------------------------------------------
    regfile_clr_fsm #(
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_clr_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr_req  (bus.clr_req),
        .i_any_wen  (|bus.wen),
        .o_busy     (w_busy),
        .o_wr_drop  (w_wr_drop),
        .o_clr_en   (w_clr_en),
        .o_clr_addr (w_clr_addr)
    );

    assign bus.busy    = w_busy;
    assign bus.wr_drop = w_wr_drop;

    // ------------------------------------------------------------------
    // Storage. Writes are only accepted while the sweep is idle; the
    // ascending port loop lets the higher port index win an address
    // collision because its non-blocking update is scheduled last.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
            r_valid <= '0;
        end else if (w_clr_en) begin
            r_mem[w_clr_addr]   <= '0;
            r_valid[w_clr_addr] <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.wen[k]) begin
                    r_mem[w_wr_addr[k]]   <= w_wr_data[k];
                    r_valid[w_wr_addr[k]] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Array read (current contents, no bypass)
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        w_rd_vld  = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            w_rd_data[j*DWIDTH +: DWIDTH] = r_mem[w_rd_addr[j]];
            w_rd_vld[j]                   = r_valid[w_rd_addr[j]];
        end
    end

    // ------------------------------------------------------------------
    // Read output stage
    // ------------------------------------------------------------------
    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [NUM_RD*DWIDTH-1:0] w_byp_data;
            logic [NUM_RD-1:0]        w_byp_vld;
            logic [NUM_RD*DWIDTH-1:0] r_d_out;
            logic [NUM_RD-1:0]        r_rd_valid;

            // Write-through: a write accepted at the same edge overrides the
            // stale array value, so the registered read returns new data.
            always_comb begin
                w_byp_data = w_rd_data;
                w_byp_vld  = w_rd_vld;
                if (!w_clr_en) begin
                    for (int j = 0; j < NUM_RD; j++) begin
                        for (int k = 0; k < NUM_WR; k++) begin
                            if (bus.wen[k] && (w_wr_addr[k] == w_rd_addr[j])) begin
                                w_byp_data[j*DWIDTH +: DWIDTH] = w_wr_data[k];
                                w_byp_vld[j]                   = 1'b1;
                            end
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d_out    <= '0;
                    r_rd_valid <= '0;
                end else begin
                    r_d_out    <= w_byp_data;
                    r_rd_valid <= w_byp_vld;
                end
            end

            assign bus.d_out    = r_d_out;
            assign bus.rd_valid = r_rd_valid;
        end else begin : g_rd_comb
            assign bus.d_out    = w_rd_data;
            assign bus.rd_valid = w_rd_vld;
        end
    endgenerate

endmodule : regfile_mp
`default_nettype wire
